workers_cpu_2_cpu_mult_seq: RTL and testbench

//  Two-port arbitrated sequencer for the CPU 3-cell 16x16 partial-product multiplier (lo*lo, lo*hi, hi*lo).

---
 rtl/workers_cpu_2_cpu_mult_seq.sv | 180 ++++++++++++++++++
 tb/tb_workers_cpu_2_cpu_mult_seq.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/workers_cpu_2_cpu_mult_seq.sv
// workers_cpu_2_cpu_mult_seq
//   Two-port round-robin sequencer for the 3-cell 16x16 partial-product
//   multiplier. Computes the low or high 32 bits of a 32x32 unsigned product.
//   The high word needs a second cell pass to form hi*hi.
//   One operation is in flight at a time.
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   req_valid/req_ready[1:0]     per-requester request handshake
//   req_op_hi[1:0]               0 = low word, 1 = high word (unsigned)
//   req_a0/req_b0, req_a1/req_b1 operands for port0 / port1
//   rsp_valid[1:0]/rsp_ready     one-hot response handshake to the granted port
//   rsp_result                   shared result word, qualified by rsp_valid
//   mc_src1/mc_src2/mc_en        multiplier cell operands and enable
//   mc_p1/mc_p2/mc_p3            cell products lo*lo, lo*hi, hi*lo
module workers_cpu_2_cpu_mult_seq #(
  parameter int unsigned RR_RESET_PRI = 0,
  parameter int unsigned CELL_LAT     = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [1:0]  req_op_hi,
  input  logic [31:0] req_a0,
  input  logic [31:0] req_b0,
  input  logic [31:0] req_a1,
  input  logic [31:0] req_b1,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [31:0] rsp_result,
  output logic [31:0] mc_src1,
  output logic [31:0] mc_src2,
  output logic        mc_en,
  input  logic [31:0] mc_p1,
  input  logic [31:0] mc_p2,
  input  logic [31:0] mc_p3
);

  localparam int unsigned CW = (CELL_LAT > 1) ? $clog2(CELL_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE_LO,
    S_WAIT_LO,
    S_ISSUE_HI,
    S_WAIT_HI,
    S_RESP
  } state_t;

  state_t        state, next_state;
  logic          ptr;
  logic          gnt_q;
  logic          op_hi_q;
  logic [15:0]   a_hi_q, b_hi_q;
  logic [CW-1:0] cnt;
  logic [31:0]   p1_q, p2_q, p3_q, hh_q;

  logic          grant_any, gnt, cnt_last, cap_lo, cap_hi, load_rsp, rsp_done;
  logic [32:0]   mid;
  logic [63:0]   prod;
  logic [31:0]   result;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    req_ready  = '0;
    mc_en      = 1'b0;
    grant_any  = 1'b0;
    gnt        = ptr;
    cnt_last   = (cnt == '0);
    cap_lo     = 1'b0;
    cap_hi     = 1'b0;
    load_rsp   = 1'b0;
    rsp_done   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (req_valid != 2'b00) begin
          grant_any      = 1'b1;
          // Single requester: its own index; both: the pointer port.
          gnt            = (req_valid == 2'b11) ? ptr : req_valid[1];
          req_ready[gnt] = 1'b1;
          next_state     = S_ISSUE_LO;
        end
      end
      S_ISSUE_LO: begin
        mc_en      = 1'b1;
        next_state = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (cnt_last) begin
          cap_lo     = 1'b1;
          next_state = op_hi_q ? S_ISSUE_HI : S_RESP;
        end
      end
      S_ISSUE_HI: begin
        mc_en      = 1'b1;
        next_state = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (cnt_last) begin
          cap_hi     = 1'b1;
          next_state = S_RESP;
        end
      end
      S_RESP: begin
        // First RESP cycle registers the result; handshake is taken afterwards.
        if (rsp_valid == 2'b00) begin
          load_rsp = 1'b1;
        end else if (rsp_ready[gnt_q]) begin
          rsp_done   = 1'b1;
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // mid keeps the carry of p2+p3; hh only reaches bits 63:32.
  always_comb begin
    mid    = {1'b0, p2_q} + {1'b0, p3_q};
    prod   = {32'h0, p1_q} + {15'h0, mid, 16'h0} + {hh_q, 32'h0};
    result = op_hi_q ? prod[63:32] : prod[31:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr        <= 1'(RR_RESET_PRI);
      gnt_q      <= 1'b0;
      op_hi_q    <= 1'b0;
      a_hi_q     <= '0;
      b_hi_q     <= '0;
      cnt        <= '0;
      p1_q       <= '0;
      p2_q       <= '0;
      p3_q       <= '0;
      hh_q       <= '0;
      mc_src1    <= '0;
      mc_src2    <= '0;
      rsp_valid  <= '0;
      rsp_result <= '0;
    end else begin
      if (grant_any) begin
        ptr     <= ~gnt;
        gnt_q   <= gnt;
        op_hi_q <= req_op_hi[gnt];
        a_hi_q  <= gnt ? req_a1[31:16] : req_a0[31:16];
        b_hi_q  <= gnt ? req_b1[31:16] : req_b0[31:16];
        mc_src1 <= gnt ? req_a1 : req_a0;
        mc_src2 <= gnt ? req_b1 : req_b0;
      end
      if (state == S_ISSUE_LO || state == S_ISSUE_HI) begin
        cnt <= CW'(CELL_LAT - 1);
      end else if ((state == S_WAIT_LO || state == S_WAIT_HI) && !cnt_last) begin
        cnt <= cnt - 1'b1;
      end
      if (cap_lo) begin
        p1_q <= mc_p1;
        p2_q <= mc_p2;
        p3_q <= mc_p3;
        // Operands switch at the WAIT_LO exit so they are in place for ISSUE_HI.
        if (op_hi_q) begin
          mc_src1 <= {16'h0, a_hi_q};
          mc_src2 <= {16'h0, b_hi_q};
        end
      end
      if (cap_hi) hh_q <= mc_p1;
      if (load_rsp) begin
        rsp_valid  <= gnt_q ? 2'b10 : 2'b01;
        rsp_result <= result;
      end else if (rsp_done) begin
        rsp_valid  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_workers_cpu_2_cpu_mult_seq.sv
module tb_workers_cpu_2_cpu_mult_seq;
  localparam int LAT = 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  req_valid = '0, req_ready, req_op_hi = '0;
  logic [31:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
  logic [1:0]  rsp_valid, rsp_ready = '0;
  logic [31:0] rsp_result, mc_src1, mc_src2;
  logic        mc_en;
  logic [31:0] mc_p1 = '0, mc_p2 = '0, mc_p3 = '0;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  workers_cpu_2_cpu_mult_seq #(.RR_RESET_PRI(0), .CELL_LAT(LAT)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op_hi(req_op_hi),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .mc_src1(mc_src1), .mc_src2(mc_src2), .mc_en(mc_en),
    .mc_p1(mc_p1), .mc_p2(mc_p2), .mc_p3(mc_p3)
  );

  // Multiplier cell: products of an enabled cycle appear one cycle later and hold.
  always @(posedge clk) begin
    if (mc_en) begin
      mc_p1 <= 32'(mc_src1[15:0]) * 32'(mc_src2[15:0]);
      mc_p2 <= 32'(mc_src1[15:0]) * 32'(mc_src2[31:16]);
      mc_p3 <= 32'(mc_src1[31:16]) * 32'(mc_src2[15:0]);
    end
  end

  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic hi);
    logic [63:0] p;
    p = {32'h0, a} * {32'h0, b};
    return hi ? p[63:32] : p[31:0];
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // One complete operation on one port; hold = cycles of response backpressure.
  task automatic run_op(input int port, input logic [31:0] a, input logic [31:0] b,
                        input logic hi, input logic [31:0] exp, input int hold);
    int  n;
    int  pulses;
    bit  got;
    @(negedge clk);
    if (port == 0) begin req_a0 = a; req_b0 = b; end
    else begin req_a1 = a; req_b1 = b; end
    req_op_hi[port] = hi;
    req_valid[port] = 1'b1;
    rsp_ready = '0;
    #1;
    n = 0;
    while (!req_ready[port] && n < 20) begin @(negedge clk); #1; n++; end
    if (!req_ready[port]) begin
      check("grant_timeout", 0, 1);
      req_valid = '0;
      return;
    end
    check("grant_port", 64'(req_ready), (port == 1) ? 64'h2 : 64'h1);
    @(posedge clk);
    n = 0; pulses = 0; got = 0;
    while (n < 30) begin
      @(negedge clk);
      n++;
      req_valid[port] = 1'b0;
      if (n == 1) begin
        check("src1_issue_lo", 64'(mc_src1), 64'(a));
        check("src2_issue_lo", 64'(mc_src2), 64'(b));
      end
      if (mc_en) pulses++;
      if (rsp_valid != 2'b00) begin got = 1; break; end
    end
    if (!got) begin
      check("rsp_timeout", 0, 1);
      return;
    end
    check("latency", 64'(n - 1), hi ? 64'(3 + 2 * LAT) : 64'(2 + LAT));
    check("mc_en_pulses", 64'(pulses), hi ? 64'd2 : 64'd1);
    check("rsp_valid_port", 64'(rsp_valid), (port == 1) ? 64'h2 : 64'h1);
    check("rsp_result", 64'(rsp_result), 64'(exp));
    if (hold > 0) begin
      // Other port requests and acks meanwhile; both must be ignored.
      req_valid[1-port] = 1'b1;
      rsp_ready[1-port] = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk); #1;
        check("hold_rsp_valid", 64'(rsp_valid), (port == 1) ? 64'h2 : 64'h1);
        check("hold_rsp_result", 64'(rsp_result), 64'(exp));
        check("hold_req_ready", 64'(req_ready), 64'h0);
      end
      req_valid = '0;
    end
    rsp_ready = (port == 1) ? 2'b10 : 2'b01;
    #1;
    check("handshake_req_ready", 64'(req_ready), 64'h0);
    @(negedge clk);
    check("rsp_valid_fall", 64'(rsp_valid), 64'h0);
    rsp_ready = '0;
  endtask

  typedef struct {
    int          port;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi;
    logic [31:0] exp;
    int          hold;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [31:0] ra, rb, op_a[2], op_b[2];
    logic        rhi, op_h[2];
    int          rport, nresp, c, n;
    int          gseq[$], rseq[$];
    bit          bad;

    tbl[0] = '{0, 32'h0001_0003, 32'h0002_0005, 1'b0, 32'h000B_000F, 0};
    tbl[1] = '{1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 0};
    tbl[2] = '{0, 32'h0000_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_FFFE, 0};
    tbl[3] = '{1, 32'h0000_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_0001, 0};
    tbl[4] = '{0, 32'h8000_0000, 32'h0000_0002, 1'b1, 32'h0000_0001, 10};
    tbl[5] = '{1, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 3};
    tbl[6] = '{0, 32'h0001_0000, 32'h0001_0000, 1'b0, 32'h0000_0000, 0};
    tbl[7] = '{1, 32'h0001_0000, 32'h0001_0000, 1'b1, 32'h0000_0001, 1};

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_req_ready", 64'(req_ready), 64'h0);
    check("reset_rsp_valid", 64'(rsp_valid), 64'h0);
    check("reset_rsp_result", 64'(rsp_result), 64'h0);
    check("reset_mc_src1", 64'(mc_src1), 64'h0);
    check("reset_mc_src2", 64'(mc_src2), 64'h0);
    check("reset_mc_en", 64'(mc_en), 64'h0);
    reset_n = 1'b1;

    // Both ports valid continuously: alternating grants from port0
    op_a[0] = 32'h1234_5678; op_b[0] = 32'h9ABC_DEF0; op_h[0] = 1'b1;
    op_a[1] = 32'hDEAD_BEEF; op_b[1] = 32'h0000_1234; op_h[1] = 1'b0;
    @(negedge clk);
    req_a0 = op_a[0]; req_b0 = op_b[0]; req_a1 = op_a[1]; req_b1 = op_b[1];
    req_op_hi = {op_h[1], op_h[0]};
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    nresp = 0;
    for (c = 0; c < 80 && nresp < 4; c++) begin
      #1;
      if (req_ready != 2'b00) begin
        gseq.push_back(int'(req_ready[1]));
        check("rr_ready_onehot", 64'($countones(req_ready)), 64'd1);
      end
      if (rsp_valid != 2'b00) begin
        check("rr_rsp_onehot", 64'($countones(rsp_valid)), 64'd1);
        check("rr_no_grant_in_resp", 64'(req_ready), 64'h0);
        rseq.push_back(int'(rsp_valid[1]));
        check("rr_result", 64'(rsp_result),
              64'(ref_mul(op_a[rsp_valid[1]], op_b[rsp_valid[1]], op_h[rsp_valid[1]])));
        nresp++;
        if (nresp == 4) req_valid = '0;
      end
      @(negedge clk);
    end
    rsp_ready = '0;
    check("rr_resp_count", 64'(nresp), 64'd4);
    check("rr_grant_count", 64'(gseq.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < gseq.size()) check("rr_grant_order", 64'(gseq[i]), 64'(i % 2));
      if (i < rseq.size()) check("rr_rsp_order", 64'(rseq[i]), 64'(i % 2));
    end

    // Directed vectors
    foreach (tbl[i]) run_op(tbl[i].port, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].exp, tbl[i].hold);

    // Randomized operations against the arithmetic reference
    for (int i = 0; i < 40; i++) begin
      rport = int'($urandom_range(0, 1));
      rhi   = 1'($urandom_range(0, 1));
      ra    = $urandom;
      rb    = $urandom;
      case ($urandom_range(0, 4))
        0: ra = 32'hFFFF_FFFF;
        1: rb = 32'hFFFF_FFFF;
        2: begin ra[15:0] = 16'hFFFF; rb[31:16] = 16'hFFFF; end
        default: ;
      endcase
      run_op(rport, ra, rb, rhi, ref_mul(ra, rb, rhi), int'($urandom_range(0, 2)));
    end

    // Reset during WAIT_HI after port0 took priority away from itself
    @(negedge clk);
    req_a0 = 32'hABCD_1234; req_b0 = 32'h5678_9ABC; req_op_hi = 2'b01;
    req_valid = 2'b01;
    rsp_ready = '0;
    #1;
    n = 0;
    while (!req_ready[0] && n < 20) begin @(negedge clk); #1; n++; end
    check("abort_grant", 64'(req_ready), 64'h1);
    @(posedge clk);
    repeat (4) begin @(negedge clk); req_valid = '0; end
    reset_n = 1'b0;
    #1;
    check("abort_req_ready", 64'(req_ready), 64'h0);
    check("abort_rsp_valid", 64'(rsp_valid), 64'h0);
    check("abort_rsp_result", 64'(rsp_result), 64'h0);
    check("abort_mc_src1", 64'(mc_src1), 64'h0);
    check("abort_mc_src2", 64'(mc_src2), 64'h0);
    check("abort_mc_en", 64'(mc_en), 64'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid != 2'b00 || mc_en) bad = 1;
    end
    check("abort_no_activity", 64'(bad), 64'h0);
    req_valid = 2'b11;
    #1;
    check("abort_ptr_reset", 64'(req_ready), 64'h1);
    @(negedge clk);
    req_valid = '0;
    rsp_ready = 2'b11;
    repeat (10) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
